// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus-master DMA controller.
//   - dma_state_e : controller FSM state encoding (3 bits)
//   - ADDR_W_DEF / DATA_W_DEF : default Z80 address and data widths
//   - DIR_WRITE / DIR_READ : transfer direction encoding of the dir input
package z80_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic DIR_WRITE = 1'b0;  // local stream -> Z80 memory
  localparam logic DIR_READ  = 1'b1;  // Z80 memory -> local stream

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StSetup,
    StStrobe,
    StHold,
    StRelease
  } dma_state_e;

endpackage

// File: rtl/bus_sync.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clock  - destination clock
//   nRESET - synchronous active-low reset; both flops reset to all-ones
//   d      - asynchronous input
//   q      - synchronized output, two clocks of latency
module bus_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clock) begin
    if (!nRESET) begin
      meta_q <= '1;
      q      <= '1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/z80_dma_ctrl.sv
// Z80 bus-master block-transfer controller.
// Requests the Z80 bus via nBUSRQ/nBUSAK, then moves `length` bytes between a
// local byte stream and Z80 memory starting at `base`, one SETUP/STROBE/HOLD
// sequence per byte, and finally releases the bus and pulses `done`.
// Ports:
//   clock, nRESET       - clock and synchronous active-low reset
//   start/dir/base/length - command; captured only in idle
//   busy, done          - command in progress / one-cycle completion pulse
//   wr_data/wr_valid/wr_ready - write-byte stream (local -> memory)
//   rd_data/rd_valid    - read-byte stream (memory -> local), no backpressure
//   nBUSRQ, nBUSAK      - Z80 bus request (out) / acknowledge (async in)
//   nRD, nWR, ADDR, DQ  - shared Z80 pins, high-impedance unless bus is owned
module z80_dma_ctrl
  import z80_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clock,
  input  logic              nRESET,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              nBUSRQ,
  input  logic              nBUSAK,
  inout  wire               nRD,
  inout  wire               nWR,
  output wire  [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DQ
);

  localparam int unsigned ScntW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [ScntW-1:0] ScntLast = ScntW'(STROBE_CYC - 1);

  dma_state_e        state_q;
  logic              dir_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  count_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ScntW-1:0]  scnt_q;
  logic              own_q;
  logic              busrq_q;
  logic              nrd_q;
  logic              nwr_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              ak_sync;

  bus_sync #(
    .WIDTH (1)
  ) u_ak_sync (
    .clock  (clock),
    .nRESET (nRESET),
    .d      (nBUSAK),
    .q      (ak_sync)
  );

  always_ff @(posedge clock) begin
    if (!nRESET) begin
      state_q    <= StIdle;
      dir_q      <= DIR_WRITE;
      addr_q     <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      scnt_q     <= '0;
      own_q      <= 1'b0;
      busrq_q    <= 1'b1;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (length == '0) begin
              // Empty command completes without touching the bus.
              done_q <= 1'b1;
            end else begin
              dir_q   <= dir;
              addr_q  <= base;
              count_q <= length;
              busrq_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StReq;
            end
          end
        end
        StReq: begin
          if (!ak_sync) begin
            own_q   <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (dir_q == DIR_READ) begin
            nrd_q   <= 1'b0;
            scnt_q  <= '0;
            state_q <= StStrobe;
          end else if (wr_valid) begin
            wdata_q <= wr_data;
            nwr_q   <= 1'b0;
            scnt_q  <= '0;
            state_q <= StStrobe;
          end
        end
        StStrobe: begin
          if (scnt_q == ScntLast) begin
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            state_q <= StHold;
            if (dir_q == DIR_READ) begin
              rd_data_q  <= DQ;
              rd_valid_q <= 1'b1;
            end
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        StHold: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_q - 1'b1;
          if (count_q == LEN_W'(1)) begin
            own_q   <= 1'b0;
            busrq_q <= 1'b1;
            state_q <= StRelease;
          end else begin
            state_q <= StSetup;
          end
        end
        StRelease: begin
          // A grant dropped mid-transfer is ignored; only the final release matters.
          if (ak_sync) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign nBUSRQ   = busrq_q;
  assign wr_ready = (state_q == StSetup) && (dir_q == DIR_WRITE);

  assign ADDR = own_q ? addr_q : {ADDR_W{1'bz}};
  assign nRD  = own_q ? nrd_q : 1'bz;
  assign nWR  = own_q ? nwr_q : 1'bz;
  assign DQ   = (own_q && dir_q == DIR_WRITE) ? wdata_q : {DATA_W{1'bz}};

endmodule
